divider_32bit: RTL and testbench
================================

Name: divider_32bit

Overview:
Multi-cycle 32-bit integer divider for the RV32M execute stage. Computes DIV, DIVU, REM and REMU using a restoring shift-and-subtract algorithm on absolute values, then applies sign correction. It is the inverse-operation companion to the core's sequential multiplier and uses the same start/ready/done handshake toward the ALU issue logic.

Parameters:
- WIDTH, 32, operand/result width; only 32 is verified.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  reset; synchronous, active-high.
- i_start  input  1  request; sampled only in IDLE.
- i_signed_en  input  1  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU); captured with the operands.
- i_a  input  32  dividend.
- i_b  input  32  divisor.
- o_quotient  output  32  registered quotient.
- o_remainder  output  32  registered remainder.
- o_div_by_zero  output  1  registered flag; 1 when the captured divisor was 0.
- o_ready  output  1  high in IDLE only.
- o_done  output  1  one-cycle pulse in DONE; outputs are valid this cycle and held until the next DONE.

Behaviour:
- Reset:
  - State goes to IDLE.
  - o_quotient, o_remainder and o_div_by_zero go to 0; o_done goes to 0; o_ready goes to 1.
  - Reset mid-operation aborts immediately with no partial output update.
- FSM states: IDLE, FETCH, ACTIVE, DONE.
  - IDLE: captures i_a, i_b and i_signed_en every cycle. Goes to FETCH if i_start, else stays.
  - FETCH: computes absolute values and the iteration count. Goes to DONE if divisor==0, dividend==0 or signed overflow; else goes to ACTIVE.
  - ACTIVE: one quotient bit per cycle. Goes to DONE when the down-counter reaches 0.
  - DONE: loads the output registers and asserts o_done. Always goes to IDLE.
- i_start outside IDLE is ignored. Operands change only in IDLE.
- Signs:
  - sign_a = i_signed_en & a[31]; sign_b = i_signed_en & b[31].
  - Quotient is negated when sign_a^sign_b; remainder is negated when sign_a.
  - Quotient truncates toward zero.
- Datapath:
  - 33-bit partial remainder R and 32-bit shift register Q, which is loaded with |a| in FETCH.
  - Each ACTIVE cycle: T = {R[31:0], Q[31]} - {1'b0, |b|}.
    - If T is non-negative: R = T, shift 1 into Q.
    - Else: R = {R[31:0], Q[31]}, shift 0 into Q.
- Iteration count:
  - Without the optional feature: 32 ACTIVE cycles (counter loaded with 31).
  - Latency from start sampled to o_done: 34 cycles.
- Special cases, all resolved in FETCH with no ACTIVE cycles, o_done 2 cycles after start:
  - Divide by zero: quotient 0xFFFFFFFF, remainder a, o_div_by_zero=1.
  - Dividend zero (divisor nonzero): quotient 0, remainder 0.
  - Signed overflow (a=0x80000000, b=0xFFFFFFFF, signed): quotient 0x80000000, remainder 0.
- Magnitude: |0x80000000| is handled as unsigned 0x80000000; no width extension beyond 33 bits is required.
- Back-to-back: o_ready rises the cycle after DONE. A new i_start is accepted in that IDLE cycle.

Optional Feature:
- Macro: DIV_EARLY_TERM_EN.
- When defined:
  - FETCH counts leading zeros (NLZ) of |a|, loads Q with |a| << NLZ, and loads the counter with 31-NLZ.
  - ACTIVE runs 32-NLZ cycles; latency = 34-NLZ cycles.
  - Results are identical to the fixed-latency build.
- When undefined: always 32 ACTIVE cycles, and no leading-zero counter is instantiated.

Test Plan:
- Unsigned, a=100, b=7, i_signed_en=0 -> quotient 14, remainder 2. o_done exactly 34 cycles after start (without the macro); 9 cycles with DIV_EARLY_TERM_EN (NLZ=25).
- Signed, a=-7 (0xFFFFFFF9), b=2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). Same operands unsigned -> quotient 0x7FFFFFFC, remainder 1.
- Divide by zero, a=0x12345678, b=0 -> quotient 0xFFFFFFFF, remainder 0x12345678, o_div_by_zero=1, o_done 2 cycles after start.
- Signed overflow, a=0x80000000, b=0xFFFFFFFF -> quotient 0x80000000, remainder 0, o_div_by_zero=0, o_done 2 cycles after start.
- i_start held high and operands changed during ACTIVE -> ignored; the first result is unchanged. The second request is accepted in the IDLE cycle after DONE and completes correctly.
- i_rst asserted at ACTIVE cycle 10 -> next cycle IDLE, o_ready=1, o_done=0, outputs 0. The following request a=0xFFFFFFFF, b=0x10 (unsigned) -> quotient 0x0FFFFFFF, remainder 0xF.

Source files
------------

// File: rtl/divider_32bit.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU with sign correction.
// Optional macro DIV_EARLY_TERM_EN skips leading-zero iterations of the dividend.
module divider_32bit #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_signed_en,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_by_zero,
    output logic             o_ready,
    output logic             o_done
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, FETCH, ACTIVE, DONE} state_t;
    state_t state, state_next;

    logic [WIDTH-1:0] a_reg, b_reg, abs_b, q_reg, r_reg;
    logic             signed_reg, neg_q, neg_r;
    logic [CW-1:0]    cnt;

    logic             sign_a, sign_b, a_zero, b_zero, ovf;
    logic [WIDTH-1:0] abs_a, abs_b_c, q_init, q_step, r_step, q_final, r_final;
    logic [CW-1:0]    cnt_init;
    logic [WIDTH:0]   shifted, diff;

`ifdef DIV_EARLY_TERM_EN
    function automatic logic [CW-1:0] count_lz(input logic [WIDTH-1:0] v);
        logic [CW-1:0] n;
        logic          found;
        n     = '0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n = n + CW'(1);
            end
        end
        return n;
    endfunction

    logic [CW-1:0] nlz;
    assign nlz      = count_lz(abs_a);
    assign q_init   = abs_a << nlz;
    assign cnt_init = CW'(WIDTH - 1) - nlz;
`else
    assign q_init   = abs_a;
    assign cnt_init = CW'(WIDTH - 1);
`endif

    always_comb begin
        sign_a  = signed_reg & a_reg[WIDTH-1];
        sign_b  = signed_reg & b_reg[WIDTH-1];
        abs_a   = sign_a ? -a_reg : a_reg;
        abs_b_c = sign_b ? -b_reg : b_reg;
        a_zero  = (a_reg == '0);
        b_zero  = (b_reg == '0);
        ovf     = signed_reg && (a_reg == MIN_NEG) && (b_reg == '1);
        // R stays below |b|, so its 33rd bit only exists in the shifted trial value.
        shifted = {r_reg, q_reg[WIDTH-1]};
        diff    = shifted - {1'b0, abs_b};
        if (diff[WIDTH]) begin
            r_step = shifted[WIDTH-1:0];
            q_step = {q_reg[WIDTH-2:0], 1'b0};
        end else begin
            r_step = diff[WIDTH-1:0];
            q_step = {q_reg[WIDTH-2:0], 1'b1};
        end
        q_final = neg_q ? -q_step : q_step;
        r_final = neg_r ? -r_step : r_step;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_start) state_next = FETCH;
            FETCH:   state_next = (b_zero || a_zero || ovf) ? DONE : ACTIVE;
            ACTIVE:  if (cnt == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign o_ready = (state == IDLE);
    assign o_done  = (state == DONE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= IDLE;
            o_quotient    <= '0;
            o_remainder   <= '0;
            o_div_by_zero <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            signed_reg    <= 1'b0;
            abs_b         <= '0;
            q_reg         <= '0;
            r_reg         <= '0;
            cnt           <= '0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    a_reg      <= i_a;
                    b_reg      <= i_b;
                    signed_reg <= i_signed_en;
                end
                FETCH: begin
                    abs_b <= abs_b_c;
                    q_reg <= q_init;
                    r_reg <= '0;
                    cnt   <= cnt_init;
                    neg_q <= sign_a ^ sign_b;
                    neg_r <= sign_a;
                    // Special cases resolve here and go straight to DONE.
                    if (b_zero) begin
                        o_quotient    <= '1;
                        o_remainder   <= a_reg;
                        o_div_by_zero <= 1'b1;
                    end else if (a_zero) begin
                        o_quotient    <= '0;
                        o_remainder   <= '0;
                        o_div_by_zero <= 1'b0;
                    end else if (ovf) begin
                        o_quotient    <= MIN_NEG;
                        o_remainder   <= '0;
                        o_div_by_zero <= 1'b0;
                    end
                end
                ACTIVE: begin
                    r_reg <= r_step;
                    q_reg <= q_step;
                    cnt   <= cnt - CW'(1);
                    if (cnt == '0) begin
                        o_quotient    <= q_final;
                        o_remainder   <= r_final;
                        o_div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_divider_32bit.sv
// Directed self-checking bench for divider_32bit; define DIV_EARLY_TERM_EN here too
// when the DUT is built with early termination so latency expectations follow.
module tb_divider_32bit;
    logic        clk = 1'b0;
    logic        rst, start, signed_en;
    logic [31:0] a, b, quotient, remainder;
    logic        div_by_zero, ready, done;
    int          checks = 0;
    int          errors = 0;

    divider_32bit dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_signed_en(signed_en),
        .i_a(a), .i_b(b), .o_quotient(quotient), .o_remainder(remainder),
        .o_div_by_zero(div_by_zero), .o_ready(ready), .o_done(done)
    );

    always #5 clk = ~clk;

    // Expected cycles from the start-sampling edge to the edge that enters DONE.
    function automatic int exp_lat(input logic [31:0] av, input logic [31:0] bv, input logic sv);
        logic [31:0] mag;
        int          n;
        if (bv == 0 || av == 0 || (sv && av == 32'h8000_0000 && bv == 32'hFFFF_FFFF)) return 2;
        mag = (sv && av[31]) ? -av : av;
        n = 0;
        for (int i = 31; i >= 0; i--) begin
            if (mag[i]) break;
            n++;
        end
`ifdef DIV_EARLY_TERM_EN
        return 34 - n;
`else
        return (n >= 0) ? 34 : 0;
`endif
    endfunction

    // Drives one request at a negedge and waits (bounded) for o_done, sampling at negedges.
    task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                          output int lat, output logic rdy, output logic dn);
        @(negedge clk);
        a = av; b = bv; signed_en = sv; start = 1'b1;
        rdy = ready; dn = done;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start = 1'b0;
        while (done !== 1'b1 && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; signed_en = 1'b0; a = 32'h0; b = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || done !== 1'b0 || quotient !== 32'h0 || remainder !== 32'h0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset: ready=%b done=%b q=%h r=%h z=%b, required 1 0 0 0 0", ready, done, quotient, remainder, div_by_zero);
        end
        rst = 1'b0;
    endtask

    task automatic test_arith;
        logic [31:0] ta [9] = '{32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF8,
                                32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] tb_ [9] = '{32'd7, 32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFD,
                                 32'd2, 32'hFFFF_FFFF, 32'd1, 32'h10};
        logic        ts [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] tq [9] = '{32'd14, 32'hFFFF_FFFD, 32'h7FFF_FFFC, 32'hFFFF_FFFD, 32'd2,
                                32'hC000_0000, 32'h0, 32'hFFFF_FFFF, 32'h0FFF_FFFF};
        logic [31:0] tr [9] = '{32'd2, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'hFFFF_FFFE,
                                32'h0, 32'h8000_0000, 32'h0, 32'hF};
        int   lat;
        logic rdy, dn;
        for (int i = 0; i < 9; i++) begin
            run_op(ta[i], tb_[i], ts[i], lat, rdy, dn);
            checks++;
            if (quotient !== tq[i] || remainder !== tr[i] || div_by_zero !== 1'b0) begin
                errors++;
                $display("FAIL arith[%0d]: q=%h r=%h z=%b, required q=%h r=%h z=0", i, quotient, remainder, div_by_zero, tq[i], tr[i]);
            end
            checks++;
            if (lat !== exp_lat(ta[i], tb_[i], ts[i])) begin
                errors++;
                $display("FAIL arith_latency[%0d]: %0d cycles, required %0d", i, lat, exp_lat(ta[i], tb_[i], ts[i]));
            end
        end
    endtask

    task automatic test_special(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                                input logic [31:0] eq, input logic [31:0] er, input logic ez);
        int   lat;
        logic rdy, dn;
        run_op(av, bv, sv, lat, rdy, dn);
        checks++;
        if (quotient !== eq || remainder !== er || div_by_zero !== ez || lat !== 2) begin
            errors++;
            $display("FAIL special a=%h b=%h: q=%h r=%h z=%b lat=%0d, required q=%h r=%h z=%b lat=2",
                     av, bv, quotient, remainder, div_by_zero, lat, eq, er, ez);
        end
    endtask

    task automatic test_div_by_zero;
        test_special(32'hFFFF_FFFB, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);
        test_special(32'h1234_5678, 32'h0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
    endtask

    task automatic test_overflow_and_zero;
        test_special(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0, 1'b0);
        test_special(32'h0, 32'd5, 1'b1, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_back_to_back;
        int   lat;
        logic rdy, dn;
        run_op(32'd1000, 32'd10, 1'b0, lat, rdy, dn);
        run_op(32'd1001, 32'd10, 1'b0, lat, rdy, dn);
        checks++;
        if (rdy !== 1'b1 || dn !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_handshake: ready=%b done=%b after DONE, required 1 0", rdy, dn);
        end
        checks++;
        if (quotient !== 32'd100 || remainder !== 32'd1 || lat !== exp_lat(32'd1001, 32'd10, 1'b0)) begin
            errors++;
            $display("FAIL back_to_back_result: q=%h r=%h lat=%0d, required q=64 r=1 lat=%0d", quotient, remainder, lat, exp_lat(32'd1001, 32'd10, 1'b0));
        end
    endtask

    task automatic test_ignore_start;
        int lat;
        @(negedge clk);
        a = 32'd100; b = 32'd7; signed_en = 1'b0; start = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        a = 32'd85; b = 32'd3;
        while (done !== 1'b1 && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        checks++;
        if (quotient !== 32'd14 || remainder !== 32'd2 || lat !== exp_lat(32'd100, 32'd7, 1'b0)) begin
            errors++;
            $display("FAIL ignore_start_first: q=%h r=%h lat=%0d, required q=e r=2 lat=%0d", quotient, remainder, lat, exp_lat(32'd100, 32'd7, 1'b0));
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start_idle: ready=%b done=%b, required 1 0", ready, done);
        end
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start = 1'b0;
        while (done !== 1'b1 && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        checks++;
        if (quotient !== 32'd28 || remainder !== 32'd1 || lat !== exp_lat(32'd85, 32'd3, 1'b0)) begin
            errors++;
            $display("FAIL ignore_start_second: q=%h r=%h lat=%0d, required q=1c r=1 lat=%0d", quotient, remainder, lat, exp_lat(32'd85, 32'd3, 1'b0));
        end
    endtask

    task automatic test_reset_mid;
        int   lat;
        logic rdy, dn;
        @(negedge clk);
        a = 32'hFFFF_0000; b = 32'd3; signed_en = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || ready !== 1'b0 || quotient !== 32'hFFFF_FFFF || remainder !== 32'h1234_5678 || div_by_zero !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_hold: done=%b ready=%b q=%h r=%h z=%b, required 0 0 ffffffff 12345678 1", done, ready, quotient, remainder, div_by_zero);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (ready !== 1'b1 || done !== 1'b0 || quotient !== 32'h0 || remainder !== 32'h0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_abort: ready=%b done=%b q=%h r=%h z=%b, required 1 0 0 0 0", ready, done, quotient, remainder, div_by_zero);
        end
        run_op(32'hFFFF_FFFF, 32'h10, 1'b0, lat, rdy, dn);
        checks++;
        if (quotient !== 32'h0FFF_FFFF || remainder !== 32'hF || lat !== exp_lat(32'hFFFF_FFFF, 32'h10, 1'b0)) begin
            errors++;
            $display("FAIL reset_mid_recover: q=%h r=%h lat=%0d, required q=0fffffff r=f lat=%0d", quotient, remainder, lat, exp_lat(32'hFFFF_FFFF, 32'h10, 1'b0));
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_overflow_and_zero();
        test_back_to_back();
        test_ignore_start();
        test_div_by_zero();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
